// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// One access is in flight at a time; the requester's ack pulses the cycle after mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_ren,
  input  logic                  dm_wen,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] mem_din,
  input  logic                  mem_ack,
  output logic                  if_stall,
  output logic                  mem_stall
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          dm_pend;
  logic          data_win;

  assign dm_pend  = dm_ren | dm_wen;
  // Data normally wins; after STARVE_LIMIT back-to-back data grants a waiting fetch goes first.
  assign data_win = dm_pend && ((starve_cnt < CW'(STARVE_LIMIT)) || !if_req);

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = dm_pend & ~dm_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_dout   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (data_win) begin
            state    <= DATA;
            mem_cs   <= 1'b1;
            mem_we   <= dm_wen;
            mem_addr <= dm_addr;
            mem_dout <= dm_wdata;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + CW'(1);
          end else if (if_req) begin
            state      <= INST;
            mem_cs     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        INST: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_cs   <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_din;
          end
        end
        DATA: begin
          if (mem_ack) begin
            state  <= IDLE;
            mem_cs <= 1'b0;
            dm_ack <= 1'b1;
            // Stores (including simultaneous ren+wen) leave the load data register alone.
            if (!mem_we) dm_rdata <= mem_din;
          end
        end
        default: begin
          state  <= IDLE;
          mem_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of grants, memory contents and ack timing.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ack, dm_ren, dm_wen, dm_ack;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_dout, mem_din;
  logic          mem_cs, mem_we, mem_ack, if_stall, mem_stall;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_ren(dm_ren), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .if_stall(if_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    if_req = 0; if_addr = '0; dm_ren = 0; dm_wen = 0; dm_addr = '0; dm_wdata = '0;
    mem_din = '0; mem_ack = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1;
    tick(); tick();
    vectors++;
    if ({mem_cs, mem_we, if_ack, dm_ack} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0000", {mem_cs, mem_we, if_ack, dm_ack});
    end
    vectors++;
    if ({mem_addr, mem_dout, if_rdata, dm_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h %h %h %h exp all 0", mem_addr, mem_dout, if_rdata, dm_rdata);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h0000_0040;
    #1;
    vectors++;
    if (if_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_c0 got %b exp 1", if_stall); end
    tick();
    vectors++;
    if ({mem_cs, mem_we, if_ack, if_stall} !== 4'b1001 || mem_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL fetch_c1 got cs/we/ack/stall %b addr %h exp 1001 addr 40",
               {mem_cs, mem_we, if_ack, if_stall}, mem_addr);
    end
    mem_ack = 1; mem_din = 32'h1234_5678;
    tick();
    vectors++;
    if ({if_ack, mem_cs} !== 2'b10 || if_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL fetch_c2 got ack/cs %b rdata %h exp 10 12345678", {if_ack, mem_cs}, if_rdata);
    end
    if_req = 0; mem_ack = 0;
    #1;
    vectors++;
    if (if_stall !== 1'b0) begin miscompares++; $display("FAIL fetch_stall_c2 got %b exp 0", if_stall); end
    tick();
    vectors++;
    if ({if_ack, mem_cs} !== 2'b00) begin miscompares++; $display("FAIL fetch_c3 got %b exp 00", {if_ack, mem_cs}); end
  endtask

  task automatic test_conflict();
    if_req = 1; if_addr = 32'h44; dm_ren = 1; dm_addr = 32'h104;
    tick();
    vectors++;
    if (mem_cs !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_data_first got cs %b addr %h we %b exp 1 104 0", mem_cs, mem_addr, mem_we);
    end
    mem_ack = 1; mem_din = 32'hA5A5_0001;
    tick();
    vectors++;
    if ({dm_ack, if_ack} !== 2'b10 || dm_rdata !== 32'hA5A5_0001) begin
      miscompares++;
      $display("FAIL conflict_dm_ack got acks %b rdata %h exp 10 a5a50001", {dm_ack, if_ack}, dm_rdata);
    end
    dm_ren = 0; mem_ack = 0;
    #1;
    vectors++;
    if (if_stall !== 1'b1) begin miscompares++; $display("FAIL conflict_if_stall got %b exp 1", if_stall); end
    tick();
    vectors++;
    if (mem_cs !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_inst_second got cs %b addr %h we %b exp 1 44 0", mem_cs, mem_addr, mem_we);
    end
    mem_ack = 1; mem_din = 32'h0BAD_F00D;
    tick();
    vectors++;
    if ({if_ack, dm_ack} !== 2'b10 || if_rdata !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL conflict_if_ack got acks %b rdata %h exp 10 0badf00d", {if_ack, dm_ack}, if_rdata);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  task automatic test_write_wait();
    dm_wen = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if ({mem_cs, mem_we, dm_ack} !== 3'b110 || mem_addr !== 32'h100 || mem_dout !== 32'hDEAD_BEEF) begin
        miscompares++;
        $display("FAIL write_hold_c%0d got cs/we/ack %b addr %h dout %h exp 110 100 deadbeef",
                 c, {mem_cs, mem_we, dm_ack}, mem_addr, mem_dout);
      end
      mem_ack = (c == 4); mem_din = 32'h7777_0000 + c;
    end
    tick();
    vectors++;
    if ({dm_ack, mem_cs} !== 2'b10 || dm_rdata !== 32'hA5A5_0001) begin
      miscompares++;
      $display("FAIL write_ack got ack/cs %b rdata %h exp 10 a5a50001", {dm_ack, mem_cs}, dm_rdata);
    end
    dm_wen = 0; mem_ack = 0;
    tick();
    vectors++;
    if ({dm_ack, mem_cs} !== 2'b00) begin miscompares++; $display("FAIL write_after got %b exp 00", {dm_ack, mem_cs}); end
  endtask

  task automatic test_starve();
    int kinds [6];
    int exp_k [6];
    int ng;
    logic prev_cs;
    exp_k = '{2, 2, 2, 2, 1, 2};
    ng = 0; prev_cs = 0;
    if_req = 1; if_addr = 32'h48; dm_ren = 1; dm_addr = 32'h10C;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      tick();
      if (mem_cs && !prev_cs) begin
        kinds[ng] = (mem_addr >= 32'h100) ? 2 : 1;
        ng++;
      end
      prev_cs = mem_cs;
      mem_ack = mem_cs; mem_din = $urandom;
    end
    vectors++;
    if (ng != 6) begin miscompares++; $display("FAIL starve_grants got %0d exp 6", ng); end
    for (int g = 0; g < ng; g++) begin
      vectors++;
      if (kinds[g] != exp_k[g]) begin
        miscompares++;
        $display("FAIL starve_order grant %0d got %0d exp %0d (1=inst 2=data)", g, kinds[g], exp_k[g]);
      end
    end
    if_req = 0; dm_ren = 0;
    tick(); tick();
    mem_ack = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    dm_ren = 1; dm_addr = 32'h108;
    tick();
    vectors++;
    if (mem_cs !== 1'b1) begin miscompares++; $display("FAIL rstmid_grant got %b exp 1", mem_cs); end
    tick();
    rst = 1; dm_ren = 0;
    tick();
    vectors++;
    if ({mem_cs, dm_ack} !== 2'b00 || dm_rdata !== '0) begin
      miscompares++;
      $display("FAIL rstmid_abandon got cs/ack %b rdata %h exp 00 0", {mem_cs, dm_ack}, dm_rdata);
    end
    rst = 0; mem_ack = 1; mem_din = 32'hFFFF_FFFF;
    tick();
    vectors++;
    if ({mem_cs, dm_ack, if_ack} !== 3'b000 || dm_rdata !== '0) begin
      miscompares++;
      $display("FAIL rstmid_late_ack got %b rdata %h exp 000 0", {mem_cs, dm_ack, if_ack}, dm_rdata);
    end
    mem_ack = 0;
  endtask

  task automatic test_idle_ack();
    mem_ack = 1;
    for (int c = 0; c < 3; c++) begin
      mem_din = $urandom;
      tick();
      vectors++;
      if ({if_ack, dm_ack, mem_cs} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_ack_c%0d got %b exp 000", c, {if_ack, dm_ack, mem_cs});
      end
    end
    mem_ack = 0; if_req = 1; if_addr = 32'h50;
    tick();
    vectors++;
    if (mem_cs !== 1'b1 || mem_addr !== 32'h50 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_then_fetch got cs %b addr %h we %b exp 1 50 0", mem_cs, mem_addr, mem_we);
    end
    mem_ack = 1; mem_din = 32'h5555_AAAA;
    tick();
    vectors++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h5555_AAAA) begin
      miscompares++;
      $display("FAIL idle_fetch_ack got %b %h exp 1 5555aaaa", if_ack, if_rdata);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  // Requesters and memory are modelled as transactions: who should be granted next,
  // what the memory holds, and which ack/data must appear the cycle after mem_ack.
  task automatic test_random(input int ncyc);
    logic [31:0] memarr [256];
    logic        f_pend, d_pend, d_wen_m, s_we, exp_cs;
    logic [31:0] f_addr_m, d_addr_m, d_wdata_m, s_addr, s_dout, exp_if_rd, exp_dm_rd;
    int gnt, done, kind, ack_kind, wait_left, cnt, op;
    for (int i = 0; i < 256; i++) memarr[i] = $urandom;
    quiet_inputs();
    rst = 1; tick(); rst = 0;
    f_pend = 0; d_pend = 0; d_wen_m = 0; s_we = 0;
    f_addr_m = '0; d_addr_m = '0; d_wdata_m = '0; s_addr = '0; s_dout = '0;
    exp_if_rd = '0; exp_dm_rd = '0;
    gnt = 0; done = 0; kind = 0; wait_left = 0; cnt = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      if (done != 0) begin
        exp_cs = 0; kind = 0;
      end else if (gnt != 0) begin
        exp_cs = 1; kind = gnt; wait_left = $urandom_range(0, 3);
        s_we   = (gnt == 2) ? d_wen_m : 1'b0;
        s_addr = (gnt == 2) ? d_addr_m : f_addr_m;
        s_dout = d_wdata_m;
      end else begin
        exp_cs = (kind != 0);
      end
      vectors++;
      if (mem_cs !== exp_cs || (exp_cs && (mem_addr !== s_addr || mem_we !== s_we))) begin
        miscompares++;
        $display("FAIL rnd_access cyc %0d got cs %b addr %h we %b exp cs %b addr %h we %b",
                 cyc, mem_cs, mem_addr, mem_we, exp_cs, s_addr, s_we);
      end
      if (exp_cs && s_we) begin
        vectors++;
        if (mem_dout !== s_dout) begin
          miscompares++;
          $display("FAIL rnd_dout cyc %0d got %h exp %h", cyc, mem_dout, s_dout);
        end
      end
      vectors++;
      if (if_ack !== (done == 1) || dm_ack !== (done == 2) || if_rdata !== exp_if_rd || dm_rdata !== exp_dm_rd) begin
        miscompares++;
        $display("FAIL rnd_ack cyc %0d got if %b/%h dm %b/%h exp if %b/%h dm %b/%h", cyc,
                 if_ack, if_rdata, dm_ack, dm_rdata, done == 1, exp_if_rd, done == 2, exp_dm_rd);
      end
      ack_kind = done;
      done = 0; gnt = 0;
      if (ack_kind == 1) f_pend = 0;
      if (ack_kind == 2) d_pend = 0;
      if (!f_pend && $urandom_range(0, 2) != 0) begin
        f_pend = 1; f_addr_m = $urandom_range(0, 63) << 2;
      end
      if (!d_pend && $urandom_range(0, 1) != 0) begin
        d_pend = 1; op = $urandom_range(0, 3);
        d_addr_m = 32'h100 + ($urandom_range(0, 63) << 2);
        d_wdata_m = $urandom;
        d_wen_m = (op >= 2);
        dm_ren = (op != 2);
      end else if (!d_pend) begin
        dm_ren = 0;
      end
      if_req = f_pend; if_addr = f_addr_m;
      dm_wen = d_pend && d_wen_m; dm_ren = d_pend && dm_ren;
      dm_addr = d_addr_m; dm_wdata = d_wdata_m;
      if (kind != 0) begin
        if (wait_left == 0) begin
          mem_ack = 1; done = kind;
          if (s_we) begin
            memarr[s_addr[9:2]] = s_dout; mem_din = $urandom;
          end else begin
            mem_din = memarr[s_addr[9:2]];
            if (kind == 1) exp_if_rd = mem_din; else exp_dm_rd = mem_din;
          end
        end else begin
          wait_left--; mem_ack = 0; mem_din = $urandom;
        end
      end else begin
        mem_ack = $urandom_range(0, 1); mem_din = $urandom;
        if (d_pend && (cnt < STARVE || !f_pend)) gnt = 2;
        else if (f_pend) gnt = 1;
        if (!f_pend || gnt == 1) cnt = 0;
        else if (gnt == 2 && cnt < STARVE) cnt++;
      end
      #1;
      vectors++;
      if (if_stall !== (if_req && ack_kind != 1) || mem_stall !== ((dm_ren || dm_wen) && ack_kind != 2)) begin
        miscompares++;
        $display("FAIL rnd_stall cyc %0d got if %b mem %b exp if %b mem %b", cyc, if_stall, mem_stall,
                 if_req && ack_kind != 1, (dm_ren || dm_wen) && ack_kind != 2);
      end
    end
    quiet_inputs();
    tick(); tick();
  endtask

  initial begin
    rst = 1;
    quiet_inputs();
    test_reset();
    test_fetch();
    test_conflict();
    test_write_wait();
    test_starve();
    test_reset_mid();
    test_idle_ack();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
